led_scan_display: RTL and testbench
===================================

# led_scan_display

Consumer end of the CPU's display interface: captures the word the CPU presents on `led_data_in` whenever `led_cpu_enable` is asserted (syscall print) and shows it on eight multiplexed, active-low seven-segment digits in hexadecimal. A switch-driven selector can instead show the CPU's `total_cycles`, `condi_branch_num` or `uncondi_branch_num` counters. The block sits beside the CPU in the board top level and drives the display pins directly.

## Interface
- `SCAN_DIV`, 100000: clock cycles each digit stays lit; must be ≥ 2.
- `clk` input 1: system clock, shared with the CPU.
- `rst` input 1: asynchronous, active-low reset.
- `led_cpu_enable` input 1: print strobe from the CPU; may be held high for many cycles while the CPU is stalled.
- `led_data_in` input 32: word to print, valid while `led_cpu_enable` = 1.
- `total_cycles` input 32: CPU cycle counter.
- `condi_branch_num` input 32: taken conditional branch counter.
- `uncondi_branch_num` input 32: unconditional jump counter.
- `display_sel` input 2: source selector. 0 = printed word, 1 = total_cycles, 2 = condi_branch_num, 3 = uncondi_branch_num.
- `seg` output 8: cathodes, active-low. Bit mapping is {dp,g,f,e,d,c,b,a}.
- `an` output 8: anodes, active-low, one-hot-low. `an[0]` drives the rightmost digit.
- `print_count` output 16: number of print events since reset.

## Operation
- **print_latch (32 b):** loads `led_data_in` on every cycle with `led_cpu_enable` = 1. A held strobe reloads the same value, which is harmless.
- **Print counter:** `print_count` increments on each rising edge of `led_cpu_enable`, detected against a registered copy of the previous value.
  - A held strobe counts once.
  - The counter wraps from 16'hFFFF to 0.
- **Divider:** `div` counts 0..SCAN_DIV-1 and wraps. `tick` = (`div` == SCAN_DIV-1).
- **Digit index:** `idx` (3 b) increments on `tick` and wraps from 7 to 0.
- **Frame capture:** on a `tick` where `idx` == 7, `frame_word` loads the source chosen by `display_sel`.
  - The snapshot prevents tearing; all eight digits of a frame come from one value.
  - `display_sel` changes and source changes mid-frame take effect at the next frame.
  - Bypass: if `display_sel` = 0 and `led_cpu_enable` = 1 on that same cycle, `frame_word` loads `led_data_in` directly, not the old latch.
- **Output registers:** `seg` and `an` load on every `tick`.
  - `an` loads ~(1 << next_idx).
  - `seg` loads the decode of nibble next_idx of the word `frame_word` holds after that edge (the newly captured word when the frame wraps).
- **Decode:** `seg[7]` (dp) is always 1. Hex digits 0–F map to `seg` values:
  - 0–7: C0, F9, A4, B0, 99, 92, 82, F8
  - 8–F: 80, 90, 88, 83, C6, A1, 86, 8E
- **Reset values:** applied immediately on `rst` = 0, regardless of clock.
  - `print_latch`, `frame_word`, `div`, `idx`, the previous-strobe register and `print_count` all clear to 0.
  - `an` = 8'hFE, `seg` = 8'hC0, i.e. the rightmost digit shows "0".
  - Reset mid-frame abandons the frame. Scanning restarts at digit 0 on the first clock after `rst` returns high.

## Timing
- `an` and `seg` change only on the clock edge where `tick` = 1. Between ticks both outputs are stable, and exactly one `an` bit is low at all times.
- Scan and frame periods:
  - Each digit is lit for SCAN_DIV cycles.
  - A frame lasts 8·SCAN_DIV cycles.
  - A new frame starts with digit 0.
- Print latency:
  - `print_latch` updates 1 cycle after the strobe.
  - The value reaches the display at the next frame boundary. This is at most 8·SCAN_DIV cycles later, or 0 extra cycles when the strobe coincides with the wrap edge (bypass).
- `print_count` updates 1 cycle after the strobe's rising edge.
- Consecutive 1-cycle strobes on adjacent cycles (0,1,0,1) count as two prints. The latch keeps the later word.

## Test plan
- **Reset:** run with SCAN_DIV = 4, assert `rst` = 0 mid-scan, then release. Required response:
  - `an` = FE, `seg` = C0 and `print_count` = 0 immediately on assertion.
  - The first `an` change to FD occurs exactly 4 cycles after release.
- **Print and display:** pulse `led_cpu_enable` for 1 cycle with `led_data_in` = 32'h1234ABCD and `display_sel` = 0. Required response:
  - Over the following full frame, digits 0..7 show D, C, B, A, 4, 3, 2, 1.
  - The matching `seg` values are A1, C6, 83, 88, 99, B0, A4, F9.
  - `print_count` = 1.
- **Held strobe:** hold `led_cpu_enable` high for 10 cycles while `led_data_in` changes from 5 to 6 on cycle 4. Required response: `print_count` = 1 and the latched word is 6.
- **Bypass:** strobe 32'h0000000F on the exact cycle of the idx 7→0 tick. Required response: digit 0 of the new frame shows `seg` = 8E. No frame shows the old value after that edge.
- **Selector snapshot:** set `total_cycles` = 32'hFFFFFFFF and `display_sel` = 1, then switch `display_sel` to 2 at digit 3 with `condi_branch_num` = 0. Required response:
  - The current frame shows 8E on all digits.
  - The next frame shows C0 on all digits.
- **Counter wrap:** apply 65536 separate strobes. Required response: `print_count` returns to 0.

Source files
------------

// File: rtl/led_scan_display_if.sv
// CPU-to-display bus: print strobe, print word, perf counters, selector.
// The CPU side drives everything; the display side only samples.
interface led_scan_display_if;
  logic        led_cpu_enable;
  logic [31:0] led_data_in;
  logic [31:0] total_cycles;
  logic [31:0] condi_branch_num;
  logic [31:0] uncondi_branch_num;
  logic [1:0]  display_sel;

  modport master (
    output led_cpu_enable,
    output led_data_in,
    output total_cycles,
    output condi_branch_num,
    output uncondi_branch_num,
    output display_sel
  );

  modport slave (
    input led_cpu_enable,
    input led_data_in,
    input total_cycles,
    input condi_branch_num,
    input uncondi_branch_num,
    input display_sel
  );
endinterface

// File: rtl/led_scan_display.sv
// Eight-digit multiplexed hex display for CPU print words and counters.
// Frames are snapshotted at the digit-7 wrap so a frame never tears.
module led_scan_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  led_scan_display_if.slave    bus,
  output logic [7:0]           seg,
  output logic [7:0]           an,
  output logic [15:0]          print_count
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [31:0]   print_latch;
  logic [31:0]   frame_word;
  logic [31:0]   frame_nxt;
  logic [31:0]   src_word;
  logic [DW-1:0] div;
  logic [2:0]    idx;
  logic [2:0]    next_idx;
  logic          en_q;
  logic          tick;
  logic          wrap;

  function automatic logic [7:0] hex_seg(input logic [3:0] h);
    logic [7:0] s;
    unique case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign tick     = (div == DIV_MAX);
  assign wrap     = tick && (idx == 3'd7);
  assign next_idx = idx + 3'd1;

  // A strobe on the wrap edge goes straight into the new frame.
  always_comb begin
    src_word = print_latch;
    unique case (bus.display_sel)
      2'd0: src_word = bus.led_cpu_enable ? bus.led_data_in
                                          : print_latch;
      2'd1: src_word = bus.total_cycles;
      2'd2: src_word = bus.condi_branch_num;
      2'd3: src_word = bus.uncondi_branch_num;
    endcase
  end

  assign frame_nxt = wrap ? src_word : frame_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      print_latch <= '0;
      en_q        <= 1'b0;
      print_count <= '0;
    end else begin
      en_q <= bus.led_cpu_enable;
      if (bus.led_cpu_enable)
        print_latch <= bus.led_data_in;
      if (bus.led_cpu_enable && !en_q)
        print_count <= print_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div        <= '0;
      idx        <= '0;
      frame_word <= '0;
      an         <= 8'hFE;
      seg        <= 8'hC0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        idx        <= next_idx;
        frame_word <= frame_nxt;
        an         <= ~(8'h01 << next_idx);
        seg        <= hex_seg(frame_nxt[{next_idx, 2'b00} +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_led_scan_display.sv
// Randomized bench for led_scan_display against a frame-level model.
// The model derives digit and frame from the edge count since reset.
module tb_led_scan_display;

  localparam int SD    = 4;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [15:0] cnt;
  logic        chk_on = 1'b0;

  always #5 clk = ~clk;

  led_scan_display_if bus ();

  led_scan_display #(.SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .seg         (seg),
    .an          (an),
    .print_count (cnt)
  );

  logic [7:0] tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: edges since reset, latched word, frame word.
  int          n;
  logic [31:0] latch_m;
  logic [31:0] frame_m;
  logic        prev_m;
  logic [15:0] cnt_m;

  function automatic logic [31:0] src_m();
    case (bus.display_sel)
      2'd0:    return bus.led_cpu_enable ? bus.led_data_in : latch_m;
      2'd1:    return bus.total_cycles;
      2'd2:    return bus.condi_branch_num;
      default: return bus.uncondi_branch_num;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n       <= 0;
      latch_m <= '0;
      frame_m <= '0;
      prev_m  <= 1'b0;
      cnt_m   <= '0;
    end else begin
      if (bus.led_cpu_enable && !prev_m)
        cnt_m <= cnt_m + 16'd1;
      prev_m <= bus.led_cpu_enable;
      n      <= n + 1;
      if ((n + 1) % FRAME == 0)
        frame_m <= src_m();
      if (bus.led_cpu_enable)
        latch_m <= bus.led_data_in;
    end
  end

  always @(negedge clk) begin
    if (rst && chk_on) begin
      int d;
      logic [7:0] a_exp;
      d     = (n / SD) % 8;
      a_exp = ~(8'h01 << d);
      chk("an", an, a_exp);
      chk("seg", seg, tbl[frame_m[d*4 +: 4]]);
      chk("cnt", cnt, cnt_m);
    end
  end

  task automatic wait_phase(input int r);
    int k;
    k = 0;
    @(negedge clk);
    while (n % FRAME != r && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      tests++;
      fails++;
      $display("FAIL wait_phase timeout r=%0d", r);
    end
  endtask

  logic [7:0] dig_exp [8] = '{
    8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9
  };

  initial begin
    int k;
    bus.led_cpu_enable     = 1'b0;
    bus.led_data_in        = '0;
    bus.total_cycles       = '0;
    bus.condi_branch_num   = '0;
    bus.uncondi_branch_num = '0;
    bus.display_sel        = 2'd0;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    chk_on = 1'b1;

    // Dirty the state, then reset mid-scan.
    @(negedge clk);
    bus.led_cpu_enable = 1'b1;
    bus.led_data_in    = 32'h89ABCDEF;
    @(negedge clk);
    bus.led_cpu_enable = 1'b0;
    repeat (FRAME + 6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_an", an, 8'hFE);
    chk("rst_seg", seg, 8'hC0);
    chk("rst_cnt", cnt, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    while (an == 8'hFE && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rst_first_scan", k, 4);
    chk("rst_an_fd", an, 8'hFD);

    // Single print shown over the next full frame.
    @(negedge clk);
    bus.led_cpu_enable = 1'b1;
    bus.led_data_in    = 32'h1234ABCD;
    @(negedge clk);
    bus.led_cpu_enable = 1'b0;
    bus.led_data_in    = 32'hDEADBEEF;
    chk("print_cnt", cnt, 1);
    wait_phase(0);
    for (int i = 0; i < 8; i++) begin
      chk("print_dig", seg, dig_exp[i]);
      if (i < 7) repeat (SD) @(negedge clk);
    end

    // Held strobe counts once and keeps the last word.
    @(negedge clk);
    bus.led_cpu_enable = 1'b1;
    bus.led_data_in    = 32'd5;
    repeat (4) @(negedge clk);
    bus.led_data_in = 32'd6;
    repeat (6) @(negedge clk);
    bus.led_cpu_enable = 1'b0;
    @(negedge clk);
    chk("held_cnt", cnt, 2);
    chk("held_latch", dut.print_latch, 32'd6);

    // Strobe exactly on the wrap edge.
    wait_phase(FRAME - 1);
    bus.led_cpu_enable = 1'b1;
    bus.led_data_in    = 32'h0000000F;
    @(negedge clk);
    bus.led_cpu_enable = 1'b0;
    bus.led_data_in    = 32'h0;
    chk("bypass_seg", seg, 8'h8E);
    chk("bypass_an", an, 8'hFE);

    // Selector switch mid-frame takes effect next frame.
    wait_phase(FRAME - 1);
    bus.total_cycles     = 32'hFFFFFFFF;
    bus.condi_branch_num = 32'h0;
    bus.display_sel      = 2'd1;
    for (int i = 0; i < 16; i++) begin
      repeat ((i == 0) ? 1 : SD) @(negedge clk);
      chk("sel_snap", seg, (i < 8) ? 8'h8E : 8'hC0);
      if (i == 3) bus.display_sel = 2'd2;
    end

    // Randomized traffic against the model.
    repeat (3000) begin
      @(negedge clk);
      bus.led_cpu_enable = ($urandom_range(0, 3) == 0);
      bus.led_data_in    = $urandom;
      if ($urandom_range(0, 15) == 0)
        bus.display_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        bus.total_cycles       = $urandom;
        bus.condi_branch_num   = $urandom;
        bus.uncondi_branch_num = $urandom;
      end
    end
    @(negedge clk);
    bus.led_cpu_enable = 1'b0;
    @(negedge clk);

    // Counter wrap: preload near the top, then strobe across it.
    @(posedge clk);
    #1 force dut.print_count = 16'hFFFE;
    cnt_m = 16'hFFFE;
    #1 release dut.print_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.led_cpu_enable = 1'b1;
      @(negedge clk);
      bus.led_cpu_enable = 1'b0;
      if (i == 1) chk("cnt_wrap0", cnt, 16'h0);
    end
    chk("cnt_wrap1", cnt, 16'h1);
    repeat (4) @(negedge clk);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
